// File: rtl/tt_response_checker.sv
// tt_response_checker: receive end of an exhaustive truth-table sweep.
// A LEARN session records the golden response of every input pattern.
// A CHECK session compares a suspect netlist against that table.
// It reports a per-compare mismatch pulse, a saturating count and the first failing pattern.
// Optional build macro TT_CHECK_MISR_EN adds a 16-bit MISR signature output 'sig'.
module tt_response_checker #(
    parameter int N_IN  = 5,
    parameter int OUT_W = 1,
    parameter int CNT_W = N_IN + 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_learn,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [N_IN-1:0]  pat_in,
    input  logic [OUT_W-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_pat,
    output logic             table_valid
`ifdef TT_CHECK_MISR_EN
    ,
    output logic [15:0]      sig
`endif
);

    localparam int DEPTH = 1 << N_IN;

    typedef enum logic [1:0] {S_IDLE, S_LEARN, S_CHECK, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [DEPTH-1:0] cover_map;
    logic [DEPTH-1:0] cover_set;
    logic [OUT_W-1:0] golden [DEPTH];
    logic             accept;
    logic             sess_start;
    logic             last_cover;
    logic             resp_ne;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef TT_CHECK_MISR_EN
    // One MISR step, polynomial x^16+x^12+x^5+1, input word XORed in.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
        return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ d;
    endfunction
`endif

    // Transfer qualification, session start gating and coverage lookahead.
    always_comb begin
        accept     = pat_valid && pat_ready;
        // CHECK without a learned table is refused outright.
        sess_start = start && (state == S_IDLE || state == S_DONE) &&
                     (mode_learn || table_valid);
        cover_set  = cover_map | (DEPTH'(1) << pat_in);
        last_cover = accept && (&cover_set);
        resp_ne    = (resp_in != golden[pat_in]);
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        pat_ready = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (sess_start) state_nxt = mode_learn ? S_LEARN : S_CHECK;
            end
            S_LEARN, S_CHECK: begin
                busy      = 1'b1;
                pat_ready = 1'b1;
                if (last_cover) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CK) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Golden table write; contents deliberately survive reset.
    always_ff @(posedge CK) begin
        if (accept && state == S_LEARN) golden[pat_in] <= resp_in;
    end

    // Compare stage: coverage, registered mismatch pulse, count and first-fail capture.
    always_ff @(posedge CK) begin
        if (!reset) begin
            cover_map        <= '0;
            mismatch         <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_pat   <= '0;
            done             <= 1'b0;
            table_valid      <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (sess_start) begin
                cover_map        <= '0;
                mismatch_cnt     <= '0;
                first_fail_valid <= 1'b0;
                first_fail_pat   <= '0;
                done             <= 1'b0;
            end else if (accept) begin
                cover_map <= cover_set;
                if (last_cover) begin
                    done <= 1'b1;
                    if (state == S_LEARN) table_valid <= 1'b1;
                end
                if (state == S_CHECK && resp_ne) begin
                    mismatch     <= 1'b1;
                    mismatch_cnt <= sat_inc(mismatch_cnt);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_pat   <= pat_in;
                    end
                end
            end
        end
    end

`ifdef TT_CHECK_MISR_EN
    // Signature: seeded at session start, folds every accepted {pattern, response}.
    always_ff @(posedge CK) begin
        if (!reset)          sig <= 16'h0000;
        else if (sess_start) sig <= 16'hFFFF;
        else if (accept)     sig <= misr_step(sig, 16'({pat_in, resp_in}));
    end
`endif

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: session-level model plus directed sweeps.
module tb_tt_response_checker;

    localparam int N_IN    = 5;
    localparam int OUT_W   = 1;
    localparam int CNT_W   = 6;
    localparam int DEPTH   = 32;
    localparam int CNT_MAX = 63;

    logic             CK = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             mode_learn = 1'b0;
    logic             pat_valid = 1'b0;
    logic [N_IN-1:0]  pat_in = '0;
    logic [OUT_W-1:0] resp_in = '0;
    logic             pat_ready, busy, done, mismatch, first_fail_valid, table_valid;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [N_IN-1:0]  first_fail_pat;

    tt_response_checker #(.N_IN(N_IN), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .CK(CK), .reset(reset), .start(start), .mode_learn(mode_learn),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_in(pat_in), .resp_in(resp_in),
        .busy(busy), .done(done), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_pat(first_fail_pat),
        .table_valid(table_valid)
    );

    always #5 CK = ~CK;

    int n_vec  = 0;
    int n_err  = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Session-level model: phase 0 idle, 1 learn, 2 check, 3 done.
    int m_phase   = 0;
    bit m_gold [DEPTH];
    bit m_gold_ok = 0;
    bit m_seen [DEPTH];
    int m_seen_n  = 0;
    int m_fails   = 0;
    int m_first   = -1;
    bit m_pulse   = 0;
    int m_p;

    always @(posedge CK) begin
        if (!reset) begin
            m_phase = 0; m_gold_ok = 0; m_seen_n = 0; m_fails = 0; m_first = -1; m_pulse = 0;
            foreach (m_seen[i]) m_seen[i] = 0;
        end else begin
            m_pulse = 0;
            if ((m_phase == 0 || m_phase == 3) && start && (mode_learn || m_gold_ok)) begin
                m_phase = mode_learn ? 1 : 2;
                m_seen_n = 0; m_fails = 0; m_first = -1;
                foreach (m_seen[i]) m_seen[i] = 0;
            end else if ((m_phase == 1 || m_phase == 2) && pat_valid) begin
                m_p = int'(pat_in);
                if (m_phase == 1) m_gold[m_p] = resp_in[0];
                else if (m_gold[m_p] != resp_in[0]) begin
                    m_pulse = 1;
                    m_fails = (m_fails + 1 > CNT_MAX) ? CNT_MAX : m_fails + 1;
                    if (m_first < 0) m_first = m_p;
                end
                if (!m_seen[m_p]) begin m_seen[m_p] = 1; m_seen_n++; end
                if (m_seen_n == DEPTH) begin
                    if (m_phase == 1) m_gold_ok = 1;
                    m_phase = 3;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CK) begin
        chk("busy",      32'(busy),             32'(m_phase == 1 || m_phase == 2));
        chk("pat_ready", 32'(pat_ready),        32'(m_phase == 1 || m_phase == 2));
        chk("done",      32'(done),             32'(m_phase == 3 && m_seen_n == DEPTH));
        chk("mismatch",  32'(mismatch),         32'(m_pulse));
        chk("cnt",       32'(mismatch_cnt),     32'(m_fails));
        chk("ff_valid",  32'(first_fail_valid), 32'(m_first >= 0));
        chk("ff_pat",    32'(first_fail_pat),   32'((m_first >= 0) ? m_first : 0));
        chk("tbl_valid", 32'(table_valid),      32'(m_gold_ok));
        if (mismatch) pulses++;
    end

    function automatic bit par(input int p);
        return ^p[4:0];
    endfunction

    // All tasks start and end on a falling edge.
    task automatic do_start(input bit learn);
        start = 1'b1; mode_learn = learn;
        @(negedge CK);
        start = 1'b0; mode_learn = 1'b0;
    endtask

    task automatic send(input int p, input bit r);
        pat_valid = 1'b1; pat_in = N_IN'(p); resp_in = r;
        @(negedge CK);
        pat_valid = 1'b0;
    endtask

    task automatic full_learn();
        do_start(1'b1);
        for (int i = 0; i < DEPTH; i++) send(i, par(i));
    endtask

    initial begin
        repeat (3) @(negedge CK);
        reset = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tv",   32'(table_valid), 0);
        chk("rst_done", 32'(done), 0);

        // CHECK before any LEARN must be refused.
        do_start(1'b0);
        @(negedge CK);
        chk("guard_ready", 32'(pat_ready), 0);
        chk("guard_busy",  32'(busy), 0);

        // LEARN with a stray start mid-session and a 3-cycle gap.
        do_start(1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 16) do_start(1'b0);
            if (i == 20) repeat (3) @(negedge CK);
            if (i == 31) chk("learn_not_done", 32'(done), 0);
            send(i, par(i));
        end
        chk("learn_done", 32'(done), 1);
        chk("learn_tv",   32'(table_valid), 1);

        // Clean CHECK.
        do_start(1'b0);
        for (int i = 0; i < DEPTH; i++) send(i, par(i));
        chk("clean_cnt",  32'(mismatch_cnt), 0);
        chk("clean_ffv",  32'(first_fail_valid), 0);
        chk("clean_done", 32'(done), 1);

        // Single flipped response at 10110.
        do_start(1'b0);
        pulses = 0;
        for (int i = 0; i < DEPTH; i++) send(i, (i == 22) ? !par(i) : par(i));
        chk("flip_cnt",    32'(mismatch_cnt), 1);
        chk("flip_ffp",    32'(first_fail_pat), 32'h16);
        chk("flip_pulses", 32'(pulses), 1);

        // Descending with 00011 sent twice, both wrong.
        do_start(1'b0);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i == 3) begin send(3, !par(3)); send(3, !par(3)); end
            else begin
                if (i == 0) chk("desc_not_done", 32'(done), 0);
                send(i, par(i));
            end
        end
        chk("desc_done", 32'(done), 1);
        chk("desc_cnt",  32'(mismatch_cnt), 2);
        chk("desc_ffp",  32'(first_fail_pat), 3);

        // Counter saturation: 70 wrong compares of pattern 0, then the rest wrong.
        do_start(1'b0);
        repeat (70) send(0, !par(0));
        chk("sat_cnt_a", 32'(mismatch_cnt), 63);
        chk("sat_busy",  32'(busy), 1);
        for (int i = 1; i < DEPTH; i++) send(i, !par(i));
        chk("sat_cnt_b", 32'(mismatch_cnt), 63);
        chk("sat_ffp",   32'(first_fail_pat), 0);

        // Reset after 10 LEARN accepts.
        do_start(1'b1);
        for (int i = 0; i < 10; i++) send(i, par(i));
        reset = 1'b0;
        @(negedge CK);
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tv",   32'(table_valid), 0);
        chk("abort_cnt",  32'(mismatch_cnt), 0);
        chk("abort_done", 32'(done), 0);
        do_start(1'b0);
        @(negedge CK);
        chk("abort_guard", 32'(busy), 0);
        full_learn();
        chk("relearn_tv", 32'(table_valid), 1);
        do_start(1'b0);
        for (int i = 0; i < DEPTH; i++) send(i, par(i));
        chk("final_cnt",  32'(mismatch_cnt), 0);
        chk("final_done", 32'(done), 1);

        repeat (2) @(negedge CK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Receive end of the exhaustive truth-table stimulus flow: consumes (pattern, response) pairs produced while a DUT is swept through all 2^N_IN input combinations.
- LEARN session: stores the golden truth table from a known-clean netlist.
- CHECK session: compares a suspect netlist's responses against the stored table and reports mismatch count and first failing pattern, the trojan-detection verdict.
- Sits between the DUT response path and the result/status registers.

Parameters:
- N_IN, 5, pattern width; table depth = 2^N_IN.
- OUT_W, 1, response width per pattern.
- CNT_W, N_IN+1, mismatch counter width; must hold 2^N_IN.

Ports:
- CK  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising CK; 0 = reset.
- start  input  1  one-cycle pulse; begins a session when in IDLE or DONE.
- mode_learn  input  1  sampled with start: 1 = LEARN, 0 = CHECK.
- pat_valid  input  1  pair valid.
- pat_ready  output  1  pair accepted when pat_valid & pat_ready.
- pat_in  input  N_IN  applied pattern.
- resp_in  input  OUT_W  DUT response to pat_in.
- busy  output  1  session in progress.
- done  output  1  level; all 2^N_IN patterns covered.
- mismatch  output  1  one-cycle pulse per failing compare.
- mismatch_cnt  output  CNT_W  failing compares this session.
- first_fail_valid  output  1  first_fail_pat holds valid data.
- first_fail_pat  output  N_IN  pattern of first failing compare.
- table_valid  output  1  a complete LEARN session has finished.

Behaviour:
- Reset (reset=0 at edge): state IDLE; every output 0; coverage bitmap cleared; table_valid=0.
- Golden table contents are not cleared by reset.
- States: IDLE, LEARN, CHECK, DONE.
  - IDLE/DONE + start: go to LEARN if mode_learn=1, else to CHECK.
  - On that transition: clear coverage bitmap, mismatch_cnt, first_fail_valid, first_fail_pat, done.
  - CHECK with table_valid=0: rejected; stay in state, no outputs change.
- start while in LEARN or CHECK is ignored.
- pat_ready = 1 exactly in LEARN and CHECK; 0 otherwise. No other back-pressure, so a transfer occurs every cycle pat_valid=1.
- LEARN accept: table[pat_in] <= resp_in; cover[pat_in] <= 1. Duplicate pattern overwrites its entry and does not change coverage.
- CHECK accept: compare resp_in with table[pat_in], registered.
  - On inequality, in the following cycle: mismatch=1 and mismatch_cnt+1.
  - If first_fail_valid=0: latch first_fail_pat=pat_in and set first_fail_valid.
  - Duplicate pattern is compared and counted again.
  - mismatch_cnt saturates at 2^CNT_W-1.
- Completion: the cycle after the accept that sets the last cover bit:
  - state goes to DONE, done=1, busy=0.
  - In LEARN, table_valid=1.
  - Any mismatch pulse from that final compare is issued in the same cycle.
- busy = 1 in LEARN and CHECK.
- Patterns may arrive in any order; sweep order does not matter.
- reset=0 mid-session: abort to IDLE with all outputs 0.
  - Table entries written so far are kept, but table_valid=0 until a full LEARN completes.
- pat_valid outside LEARN/CHECK: ignored.

Optional Feature:
- Macro TT_CHECK_MISR_EN.
- Defined:
  - adds output sig[15:0].
  - 16-bit MISR with polynomial x^16+x^12+x^5+1, seed 16'hFFFF at session start.
  - Folds {pat_in, resp_in}, zero-extended to 16 bits, into the MISR on every accept.
  - sig is valid while done=1; reset value 0.
- Not defined: no sig port, no MISR logic; all other behaviour identical.

Test Plan:
- Learn-then-check, clean: LEARN with 32 pairs 00000..11111, resp = parity(pat) -> done, table_valid=1. CHECK with the same pairs -> mismatch_cnt=0, first_fail_valid=0, done=1 after 32nd accept +1 cycle.
- Single flip: CHECK as above but resp at 10110 inverted -> exactly one mismatch pulse, mismatch_cnt=1, first_fail_pat=10110.
- Out-of-order and duplicates: CHECK descending 11111..00000 with 00011 sent twice, both wrong -> mismatch_cnt=2, first_fail_pat=00011. done only once all 32 are covered.
- Guards: CHECK start after reset (table_valid=0) -> stays IDLE, pat_ready=0. start pulsed mid-LEARN -> ignored, session completes normally.
- Reset mid-session: reset=0 after 10 LEARN accepts -> next cycle all outputs 0, state IDLE, table_valid=0. New full LEARN -> table_valid=1.
- Gap handling: pat_valid low for 3 cycles between accepts -> no state change, counts unaffected.
